// File: rtl/mac_accum_pipe.sv
// Pipelined signed multiply-accumulate over framed vectors (acc = bias + sum a*b).
// Stages: S1 product register, S2 accumulator/framing FSM, then output register with backpressure.
module mac_accum_pipe #(
    parameter int unsigned A_W    = 9,
    parameter int unsigned B_W    = 2,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 8,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [ACC_W-1:0] in_bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             seq_err
);

    localparam int unsigned      P_W     = A_W + B_W;
    localparam int unsigned      S_W     = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < P_W) begin : g_width_check
        $error("mac_accum_pipe: ACC_W (%0d) must be >= A_W + B_W (%0d)", ACC_W, P_W);
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    typedef struct packed {
        logic             first;
        logic             last;
        logic [ACC_W-1:0] bias;
        logic [P_W-1:0]   p;
    } s1_t;

    logic             w_stall;
    logic             w_adv;
    logic [P_W-1:0]   w_a_ext;
    logic [P_W-1:0]   w_b_ext;
    logic [P_W-1:0]   w_prod;
    s1_t              w_s1_d;
    s1_t              r_s1;
    logic             r_s1_valid;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_seq_err;
    logic             w_seq_err_nxt;
    logic             r_s2_done;
    logic             w_s2_done_nxt;

    logic             w_open;
    logic             w_start;
    logic             w_bad_frame;
    logic [ACC_W-1:0] w_base;
    logic [S_W-1:0]   w_sum;
    logic             w_beat_ovf;
    logic [ACC_W-1:0] w_acc_res;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovf;

    // A pending result that downstream refuses freezes every stage.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_adv    = r_s1_valid & ~w_stall;

    // Sign-extend to the full product width; the low P_W bits are the exact signed product.
    assign w_a_ext = {{B_W{in_a[A_W-1]}}, in_a};
    assign w_b_ext = {{A_W{in_b[B_W-1]}}, in_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_s1_d  = {in_first, in_last, in_bias, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1_d;
            end
        end
    end

    // A beat without an open vector starts one from zero; a first inside an open vector restarts it.
    assign w_open      = (r_state == ST_ACC);
    assign w_start     = r_s1.first | ~w_open;
    assign w_bad_frame = (w_open & r_s1.first) | (~w_open & ~r_s1.first);
    assign w_base      = r_s1.first ? r_s1.bias : (w_open ? r_acc : '0);
    assign w_sum       = {w_base[ACC_W-1], w_base} + {{(S_W-P_W){r_s1.p[P_W-1]}}, r_s1.p};
    assign w_beat_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_res   = (SAT_EN && w_beat_ovf) ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                : w_sum[ACC_W-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_ovf_nxt     = r_ovf;
        w_seq_err_nxt = r_seq_err;
        w_s2_done_nxt = r_s2_done;
        if (w_adv) begin
            w_acc_nxt     = w_acc_res;
            w_cnt_nxt     = w_start ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
            w_ovf_nxt     = (~w_start & r_ovf) | w_beat_ovf;
            w_seq_err_nxt = r_seq_err | w_bad_frame;
            w_s2_done_nxt = r_s1.last;
            w_state_nxt   = r_s1.last ? ST_IDLE : ST_ACC;
        end else if (!w_stall) begin
            w_s2_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_seq_err <= 1'b0;
            r_s2_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_seq_err <= w_seq_err_nxt;
            r_s2_done <= w_s2_done_nxt;
        end
    end

    // Finished vector moves to the output regs; a consumed result is replaced without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_done;
            if (r_s2_done) begin
                r_out_acc <= r_acc;
                r_out_cnt <= r_cnt;
                r_out_ovf <= r_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Bench for mac_accum_pipe: saturating and wrapping instances share stimulus; directed steps
// plus a randomized phase scored against an integer-level vector model.
module tb_mac_accum_pipe;

    localparam int unsigned A_W      = 9;
    localparam int unsigned B_W      = 2;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int          ACC_MAX  = 32767;
    localparam int          ACC_MIN  = -32768;
    localparam int          CNT_MAX  = 255;
    localparam int          WAIT_MAX = 50;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_first  = 1'b0;
    logic             in_last   = 1'b0;
    logic [A_W-1:0]   in_a      = '0;
    logic [B_W-1:0]   in_b      = '0;
    logic [ACC_W-1:0] in_bias   = '0;
    logic             out_ready = 1'b1;

    logic             s_in_ready, s_out_valid, s_out_ovf, s_seq_err;
    logic [ACC_W-1:0] s_out_acc;
    logic [CNT_W-1:0] s_out_cnt;
    logic             w_in_ready, w_out_valid, w_out_ovf, w_seq_err;
    logic [ACC_W-1:0] w_out_acc;
    logic [CNT_W-1:0] w_out_cnt;

    int checks = 0;
    int errors = 0;
    int wt;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } exp_t;

    exp_t qs[$];
    exp_t qw[$];
    bit   m_open    = 1'b0;
    bit   m_seq_err = 1'b0;
    int   m_acc_s   = 0;
    int   m_acc_w   = 0;
    int   m_cnt     = 0;
    int   m_ovf_s   = 0;
    int   m_ovf_w   = 0;

    mac_accum_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
        .out_cnt(s_out_cnt), .out_ovf(s_out_ovf), .seq_err(s_seq_err)
    );

    mac_accum_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
        .out_cnt(w_out_cnt), .out_ovf(w_out_ovf), .seq_err(w_seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void apply(input int base, input int prod, input bit sat,
                                  output int res, output int ovf);
        int sum;
        sum = base + prod;
        ovf = 0;
        res = sum;
        if (sum > ACC_MAX) begin
            ovf = 1;
            res = sat ? ACC_MAX : sum - 65536;
        end else if (sum < ACC_MIN) begin
            ovf = 1;
            res = sat ? ACC_MIN : sum + 65536;
        end
    endfunction

    function automatic void model_beat(input bit f, input bit l, input int a, input int b,
                                       input int bias);
        bit   start;
        int   bs, bw, rs, rw, os, ow;
        exp_t e;
        start = f || !m_open;
        if ((m_open && f) || (!m_open && !f)) m_seq_err = 1'b1;
        bs = f ? bias : (m_open ? m_acc_s : 0);
        bw = f ? bias : (m_open ? m_acc_w : 0);
        apply(bs, a * b, 1'b1, rs, os);
        apply(bw, a * b, 1'b0, rw, ow);
        m_cnt   = start ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        m_ovf_s = (start ? 0 : m_ovf_s) | os;
        m_ovf_w = (start ? 0 : m_ovf_w) | ow;
        m_acc_s = rs;
        m_acc_w = rw;
        m_open  = !l;
        if (l) begin
            e.acc = m_acc_s; e.cnt = m_cnt; e.ovf = m_ovf_s; qs.push_back(e);
            e.acc = m_acc_w; e.cnt = m_cnt; e.ovf = m_ovf_w; qw.push_back(e);
        end
    endfunction

    // Scoreboard: values are stable at the falling edge and act on the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_open = 1'b0; m_seq_err = 1'b0; m_acc_s = 0; m_acc_w = 0;
            m_cnt = 0; m_ovf_s = 0; m_ovf_w = 0;
            qs.delete();
            qw.delete();
        end else begin
            if (s_out_valid && out_ready) begin
                chk("sat_result_expected", (qs.size() > 0) ? 1 : 0, 1);
                if (qs.size() > 0) begin
                    e = qs.pop_front();
                    chk("sat_acc", 32'($signed(s_out_acc)), e.acc);
                    chk("sat_cnt", 32'(s_out_cnt), e.cnt);
                    chk("sat_ovf", 32'(s_out_ovf), e.ovf);
                end
            end
            if (w_out_valid && out_ready) begin
                chk("wrap_result_expected", (qw.size() > 0) ? 1 : 0, 1);
                if (qw.size() > 0) begin
                    e = qw.pop_front();
                    chk("wrap_acc", 32'($signed(w_out_acc)), e.acc);
                    chk("wrap_cnt", 32'(w_out_cnt), e.cnt);
                    chk("wrap_ovf", 32'(w_out_ovf), e.ovf);
                end
            end
            if (in_valid && s_in_ready)
                model_beat(in_first, in_last, int'($signed(in_a)), int'($signed(in_b)),
                           int'($signed(in_bias)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit f, input bit l, input int a, input int b, input int bias,
                        input bit rnd, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_a     = A_W'(a);
        in_b     = B_W'(b);
        in_bias  = ACC_W'(bias);
        forever begin
            @(negedge clk);
            if (s_in_ready || waits >= WAIT_MAX) break;
            waits++;
            step();
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("accept_within_bound", (waits < WAIT_MAX) ? 1 : 0, 1);
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(s_out_valid), 0);
        chk("rst_out_acc", 32'(s_out_acc), 0);
        chk("rst_out_cnt", 32'(s_out_cnt), 0);
        chk("rst_out_ovf", 32'(s_out_ovf), 0);
        chk("rst_seq_err", 32'(s_seq_err), 0);
        chk("rst_in_ready", 32'(s_in_ready), 1);

        // Three-beat vector and its two-cycle latency
        send(1'b1, 1'b0, 3, 1, 100, 1'b0, wt);
        send(1'b0, 1'b0, -5, -1, 0, 1'b0, wt);
        send(1'b0, 1'b1, -256, -2, 0, 1'b0, wt);
        chk("t1_valid_t0", 32'(s_out_valid), 0);
        step();
        chk("t1_valid_t1", 32'(s_out_valid), 0);
        step();
        chk("t1_valid_t2", 32'(s_out_valid), 1);
        chk("t1_acc", 32'($signed(s_out_acc)), 620);
        chk("t1_cnt", 32'(s_out_cnt), 3);
        chk("t1_ovf", 32'(s_out_ovf), 0);
        step();
        step();

        // Single-beat overflow: clamp versus wrap
        send(1'b1, 1'b1, 1, 1, 32767, 1'b0, wt);
        step();
        step();
        chk("t2_sat_valid", 32'(s_out_valid), 1);
        chk("t2_sat_acc", 32'($signed(s_out_acc)), 32767);
        chk("t2_sat_ovf", 32'(s_out_ovf), 1);
        chk("t2_sat_cnt", 32'(s_out_cnt), 1);
        chk("t2_wrap_acc", 32'($signed(w_out_acc)), -32768);
        chk("t2_wrap_ovf", 32'(w_out_ovf), 1);
        step();
        step();

        // Backpressure holds the pending result and blocks input
        out_ready = 1'b0;
        send(1'b1, 1'b0, 2, 1, 10, 1'b0, wt);
        send(1'b0, 1'b1, 4, -1, 0, 1'b0, wt);
        step();
        step();
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        in_a = A_W'(5); in_b = B_W'(1); in_bias = ACC_W'(-3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_in_ready", 32'(s_in_ready), 0);
            chk("t3_valid", 32'(s_out_valid), 1);
            chk("t3_acc", 32'($signed(s_out_acc)), 8);
            chk("t3_cnt", 32'(s_out_cnt), 2);
        end
        out_ready = 1'b1;
        send(1'b1, 1'b0, 5, 1, -3, 1'b0, wt);
        send(1'b0, 1'b1, 1, 1, 0, 1'b0, wt);
        step();
        step();
        chk("t3_next_valid", 32'(s_out_valid), 1);
        chk("t3_next_acc", 32'($signed(s_out_acc)), 3);
        chk("t3_next_cnt", 32'(s_out_cnt), 2);
        step();
        step();

        // Beat without first while idle
        chk("t4_seq_err_before", 32'(s_seq_err), 0);
        send(1'b0, 1'b1, 7, 1, 0, 1'b0, wt);
        step();
        step();
        chk("t4_valid", 32'(s_out_valid), 1);
        chk("t4_acc", 32'($signed(s_out_acc)), 7);
        chk("t4_cnt", 32'(s_out_cnt), 1);
        chk("t4_seq_err", 32'(s_seq_err), 1);
        repeat (4) step();
        chk("t4_seq_err_sticky", 32'(s_seq_err), 1);
        chk("t4_wrap_seq_err_sticky", 32'(w_seq_err), 1);

        // Reset in the middle of a vector
        send(1'b1, 1'b0, 1, 1, 50, 1'b0, wt);
        send(1'b0, 1'b0, 2, 1, 0, 1'b0, wt);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 32'(s_out_valid), 0);
        chk("t5_acc", 32'(s_out_acc), 0);
        chk("t5_cnt", 32'(s_out_cnt), 0);
        chk("t5_ovf", 32'(s_out_ovf), 0);
        chk("t5_seq_err", 32'(s_seq_err), 0);
        chk("t5_in_ready", 32'(s_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_valid", 32'(s_out_valid), 0);
        end
        send(1'b1, 1'b1, 3, 1, 5, 1'b0, wt);
        step();
        step();
        chk("t5_next_acc", 32'($signed(s_out_acc)), 8);
        chk("t5_next_cnt", 32'(s_out_cnt), 1);
        chk("t5_next_seq_err", 32'(s_seq_err), 0);
        step();
        step();

        // Back-to-back single-beat vectors at full rate
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b1, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 3)) - 2,
                 int'($urandom_range(0, 65535)) - 32768, 1'b0, wt);
            chk("t6_no_wait", wt, 0);
            if (i >= 2) chk("t6_result_each_cycle", 32'(s_out_valid), 1);
        end
        repeat (4) step();

        // Long vector: counter and accumulator saturation
        for (int i = 0; i < 260; i++)
            send(i == 0, i == 259, -256, -2, 0, 1'b0, wt);
        step();
        step();
        chk("t7_sat_acc", 32'($signed(s_out_acc)), 32767);
        chk("t7_sat_cnt", 32'(s_out_cnt), 255);
        chk("t7_sat_ovf", 32'(s_out_ovf), 1);
        chk("t7_wrap_acc", 32'($signed(w_out_acc)), 2048);
        chk("t7_wrap_cnt", 32'(w_out_cnt), 255);
        chk("t7_wrap_ovf", 32'(w_out_ovf), 1);
        repeat (4) step();

        // Random framing, operands and backpressure
        for (int i = 0; i < 400; i++) begin
            bit f, l;
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) step();
            send(f, l, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 3)) - 2,
                 int'($urandom_range(0, 65535)) - 32768, 1'b1, wt);
        end
        out_ready = 1'b1;
        repeat (8) step();
        chk("t8_sat_drained", qs.size(), 0);
        chk("t8_wrap_drained", qw.size(), 0);
        chk("t8_sat_seq_err", 32'(s_seq_err), 32'(m_seq_err));
        chk("t8_wrap_seq_err", 32'(w_seq_err), 32'(m_seq_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
